// File: rtl/interp2_upsampler.sv
`default_nettype none
// ============================================================================
// Module      : interp2_upsampler
// Description : Zero-stuffing x2 upsampler feeding the halfband FIR. Buffers
//               low-rate samples in a small FIFO and emits one sample per
//               clock, alternating data and stuffed zeros, with optional
//               saturating x2 gain.
// Revision    : 1.0 - initial release
// ============================================================================
module interp2_upsampler #(
    parameter int DATA_W     = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int GAIN_SHIFT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              enable,
    output logic [DATA_W-1:0] Y,
    output logic              out_phase,
    output logic              out_active,
    output logic              underflow,
    input  logic              underflow_clr,
    output logic [2:0]        fifo_level
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PRIME = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [2:0]         r_level;

    // FSM state; r_phase selects data (0) or stuffed-zero (1) slot in RUN
    logic [1:0] r_state;
    logic       r_phase;
    logic [1:0] w_state_nxt;
    logic       w_phase_nxt;

    // Registered outputs and their next values
    logic [DATA_W-1:0] r_y;
    logic              r_out_phase;
    logic              r_out_active;
    logic              r_underflow;
    logic [DATA_W-1:0] w_y_nxt;
    logic              w_out_phase_nxt;
    logic              w_out_active_nxt;
    logic              w_uf_set;

    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_gain;

    // Ready looks only at the stored level, never at a same-cycle pop
    assign in_ready   = (r_level != 3'(FIFO_DEPTH));
    assign w_push     = in_valid & in_ready;
    assign w_empty    = (r_level == 3'd0);
    assign w_head     = r_mem[r_rd_ptr];
    assign fifo_level = r_level;
    assign Y          = r_y;
    assign out_phase  = r_out_phase;
    assign out_active = r_out_active;
    assign underflow  = r_underflow;

    generate
        if (GAIN_SHIFT != 0) begin : g_gain_x2
            // Doubling overflows exactly when the two top bits differ
            logic w_ovf;
            assign w_ovf = w_head[DATA_W-1] ^ w_head[DATA_W-2];
            // Shift left by one, clamping to the signed range on overflow
            always_comb begin
                w_gain = {w_head[DATA_W-2:0], 1'b0};
                if (w_ovf) begin
                    w_gain = w_head[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                              : {1'b0, {(DATA_W-1){1'b1}}};
                end
            end
        end else begin : g_gain_x1
            assign w_gain = w_head;
        end
    endgenerate

    // Sample storage; contents need no reset because the pointers gate reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // FSM next state; disable is only honoured after a zero slot
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            c_ST_IDLE: begin
                w_phase_nxt = 1'b0;
                if (enable) w_state_nxt = c_ST_PRIME;
            end
            c_ST_PRIME: begin
                w_phase_nxt = 1'b0;
                if (!enable)                w_state_nxt = c_ST_IDLE;
                else if (r_level >= 3'd2)   w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (!r_phase) begin
                    if (w_empty) begin
                        w_state_nxt = c_ST_PRIME;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_phase_nxt = 1'b1;
                    end
                end else begin
                    w_phase_nxt = 1'b0;
                    if (!enable) w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_phase_nxt = 1'b0;
            end
        endcase
    end

    // FSM outputs: pop and next output values for the current slot
    always_comb begin
        w_pop            = 1'b0;
        w_y_nxt          = '0;
        w_out_phase_nxt  = 1'b0;
        w_out_active_nxt = 1'b0;
        w_uf_set         = 1'b0;
        if (r_state == c_ST_RUN) begin
            if (!r_phase) begin
                if (w_empty) begin
                    w_uf_set = 1'b1;
                end else begin
                    w_pop            = 1'b1;
                    w_y_nxt          = w_gain;
                    w_out_active_nxt = 1'b1;
                end
            end else begin
                w_out_phase_nxt  = 1'b1;
                w_out_active_nxt = 1'b1;
            end
        end
    end

    // Output registers; underflow set wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y          <= '0;
            r_out_phase  <= 1'b0;
            r_out_active <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_y          <= w_y_nxt;
            r_out_phase  <= w_out_phase_nxt;
            r_out_active <= w_out_active_nxt;
            if (w_uf_set)           r_underflow <= 1'b1;
            else if (underflow_clr) r_underflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire
